// File: rtl/calc_param_if.sv
// calc_param_if: keypad command handshake plus status/display bus of the calculator
interface calc_param_if #(
    parameter int W = 27,
    parameter int POS_W = 4
);
    logic [3:0] cmd;
    logic cmd_valid;
    logic cmd_ready;
    logic [1:0] status;
    logic [3:0] data;
    logic [POS_W-1:0] pos;
    logic data_valid;
    logic [2:0] state;
    logic [W-1:0] value;
    modport master (output cmd, cmd_valid, input cmd_ready, status, data, pos, data_valid, state, value);
    modport slave (input cmd, cmd_valid, output cmd_ready, status, data, pos, data_valid, state, value);
endinterface

// File: rtl/calc_param.sv
// calc_param: keypad decimal calculator with multi-cycle mul/div and serial BCD display output
module calc_param #(
    parameter int NDIGITS = 8,
    parameter int W = 27,
    parameter int POS_W = 4
) (
    input logic clock,
    input logic reset,
    calc_param_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MAX = W'(64'(10) ** NDIGITS - 64'd1);

    typedef enum logic [2:0] {ENTER_A = 3'd0, ENTER_B = 3'd1, CALC = 3'd2, PRINT = 3'd3, ERROR = 3'd4} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t cur, nxt, pending;
    op_t op, next_op, new_op;
    logic [W-1:0] value, value_n, reg_a, reg_b, shadow, result;
    logic [2*W-1:0] acc, mul_n, div_n;
    logic [W:0] sum, mul_s, div_try;
    logic [W+3:0] app;
    logic [CW-1:0] cnt;
    logic fresh, b_entered, chain, take, is_digit, is_op, is_eq, is_bs, digit_ok, last, calc_done, calc_err;

    assign take = bus.cmd_valid && bus.cmd_ready;
    assign is_digit = bus.cmd < 4'd10;
    assign is_op = bus.cmd >= 4'd10 && bus.cmd <= 4'd13;
    assign is_eq = bus.cmd == 4'd14;
    assign is_bs = bus.cmd == 4'd15;
    assign new_op = op_t'(bus.cmd[1:0] + 2'd2);
    assign app = (W+4)'(value) * (W+4)'(10) + (W+4)'(bus.cmd);
    assign digit_ok = fresh || app <= (W+4)'(MAX);
    assign last = cnt == CW'(W - 1);
    assign sum = {1'b0, reg_a} + {1'b0, reg_b};
    // Shift-add step: add the multiplicand into the high half when the multiplier lsb is set, then shift right
    assign mul_s = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, reg_a} : '0);
    assign mul_n = {mul_s, acc[W-1:1]};
    // Restoring step: shift remainder/quotient left, keep the trial subtraction only if it did not borrow
    assign div_try = acc[2*W-1:W-1] - {1'b0, reg_b};
    assign div_n = div_try[W] ? {acc[2*W-2:0], 1'b0} : {div_try[W-1:0], acc[W-2:0], 1'b1};

    // Completion, error and result of the current CALC cycle for the selected operator
    always_comb begin
        calc_done = op == OP_ADD || op == OP_SUB || last || (op == OP_DIV && reg_b == '0);
        calc_err = op == OP_ADD ? sum > {1'b0, MAX} :
                   op == OP_SUB ? reg_a < reg_b :
                   op == OP_MUL ? mul_n > {{W{1'b0}}, MAX} : reg_b == '0;
        result = op == OP_ADD ? sum[W-1:0] :
                 op == OP_SUB ? reg_a - reg_b :
                 op == OP_MUL ? mul_n[W-1:0] : div_n[W-1:0];
    end

    // Display value after the transition about to be taken
    always_comb begin
        value_n = value;
        if (take && (cur == ENTER_A || cur == ENTER_B))
            value_n = is_digit && digit_ok ? (fresh ? W'(bus.cmd) : app[W-1:0]) :
                      is_bs ? value / W'(10) :
                      is_op && cur == ENTER_A ? '0 : value;
        else if (cur == CALC && calc_done)
            value_n = calc_err ? '0 : result;
    end

    // State register
    always_ff @(posedge clock or posedge reset)
        if (reset) cur <= ENTER_A;
        else cur <= nxt;

    // Next-state selection
    always_comb begin
        nxt = cur;
        case (cur)
            ENTER_A: if (take) nxt = (is_digit && digit_ok) || is_bs || is_op ? PRINT : ENTER_A;
            ENTER_B: if (take) nxt = (is_digit && digit_ok) || is_bs ? PRINT :
                                     is_eq || (is_op && b_entered) ? CALC : ENTER_B;
            CALC: if (calc_done) nxt = calc_err ? ERROR : PRINT;
            PRINT: if (cnt == CW'(NDIGITS - 1)) nxt = pending;
            ERROR: if (take && is_bs) nxt = PRINT;
            default: nxt = ENTER_A;
        endcase
    end

    // Outputs decoded from the current state and the print shadow
    always_comb begin
        bus.cmd_ready = cur == ENTER_A || cur == ENTER_B || cur == ERROR;
        bus.status = cur == ERROR ? 2'b00 : cur == CALC ? 2'b01 : cur == PRINT ? 2'b11 : 2'b10;
        bus.data_valid = cur == PRINT;
        bus.pos = cur == PRINT ? POS_W'(cnt) : '0;
        bus.data = cur == PRINT ? 4'(shadow % W'(10)) : 4'd0;
        bus.state = cur;
        bus.value = value;
    end

    // Operand, accumulator, step counter and print shadow registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            reg_a <= '0;
            reg_b <= '0;
            shadow <= '0;
            acc <= '0;
            cnt <= '0;
            op <= OP_ADD;
            next_op <= OP_ADD;
            pending <= ENTER_A;
            fresh <= 1'b0;
            b_entered <= 1'b0;
            chain <= 1'b0;
        end else begin
            value <= value_n;
            shadow <= cur == PRINT ? shadow / W'(10) : value_n;
            cnt <= nxt == cur ? cnt + 1'b1 : '0;
            if (nxt == PRINT && cur != PRINT)
                pending <= cur == ENTER_B || (cur == ENTER_A && is_op) || (cur == CALC && chain) ? ENTER_B : ENTER_A;
            if (nxt == CALC && cur != CALC) begin
                reg_b <= value;
                chain <= is_op;
                acc <= {{W{1'b0}}, op == OP_DIV ? reg_a : value};
                if (is_op) next_op <= new_op;
            end else if (cur == CALC)
                acc <= op == OP_MUL ? mul_n : div_n;
            if (take && cur == ENTER_A && is_op) begin
                reg_a <= value;
                op <= new_op;
                b_entered <= 1'b0;
            end else if (take && cur == ENTER_B && is_op && !b_entered)
                op <= new_op;
            else if (take && cur == ENTER_B && is_digit)
                b_entered <= 1'b1;
            else if (take && cur == ERROR && is_bs)
                reg_a <= '0;
            else if (cur == CALC && calc_done && !calc_err && chain) begin
                reg_a <= result;
                op <= next_op;
                b_entered <= 1'b0;
            end
            if (cur == CALC && calc_done && !calc_err)
                fresh <= 1'b1;
            else if (take && (is_digit || is_bs || (is_op && cur == ENTER_A)))
                fresh <= 1'b0;
        end
    end
endmodule

// File: tb/tb_calc_param.sv
// tb_calc_param: directed keypad sequences checked against a behavioural calculator model
module tb_calc_param;
    localparam int NDIGITS = 8;
    localparam int W = 27;
    localparam int POS_W = 4;
    localparam longint MAX = 99999999;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    longint m_val, m_a;
    int m_op, m_st;
    bit m_fresh, m_bent;
    int exp_q[$];
    int last_burst[NDIGITS];
    int burst_123[NDIGITS] = '{3, 2, 1, 0, 0, 0, 0, 0};

    calc_param_if #(.W(W), .POS_W(POS_W)) bus ();
    calc_param #(.NDIGITS(NDIGITS), .W(W), .POS_W(POS_W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0;
        m_a = 0;
        m_op = 10;
        m_st = 0;
        m_fresh = 0;
        m_bent = 0;
        exp_q.delete();
    endtask

    // Queue the digits of the displayed value, least significant first, tagged with position
    task automatic push_print();
        longint v = m_val;
        for (int i = 0; i < NDIGITS; i++) begin
            exp_q.push_back(i * 16 + int'(v % 10));
            v = v / 10;
        end
    endtask

    // Calculator semantics in plain arithmetic; lat = cycles from accept to print/error, 0 if no effect
    task automatic model(input int c, output int lat, output bit err);
        longint b, r;
        lat = 0;
        err = 0;
        if (m_st == 4) begin
            if (c == 15) begin
                m_val = 0; m_a = 0; m_fresh = 0; m_st = 0; lat = 1;
            end
        end else if (c < 10) begin
            if (m_st == 1) m_bent = 1;
            if (m_fresh || m_val * 10 + c <= MAX) begin
                m_val = m_fresh ? longint'(c) : m_val * 10 + c;
                m_fresh = 0;
                lat = 1;
            end
        end else if (c == 15) begin
            m_val = m_val / 10; m_fresh = 0; lat = 1;
        end else if (m_st == 0) begin
            if (c != 14) begin
                m_a = m_val; m_op = c; m_val = 0; m_fresh = 0; m_bent = 0; m_st = 1; lat = 1;
            end
        end else if (c != 14 && !m_bent) begin
            m_op = c;
        end else begin
            b = m_val;
            case (m_op)
                10: r = m_a + b;
                11: r = m_a - b;
                12: r = m_a * b;
                default: r = b == 0 ? -1 : m_a / b;
            endcase
            err = r < 0 || r > MAX;
            lat = (m_op >= 12 && !(m_op == 13 && b == 0)) ? W + 1 : 2;
            if (err) begin
                m_val = 0; m_st = 4;
            end else begin
                m_val = r; m_fresh = 1; m_st = 0;
                if (c != 14) begin
                    m_a = r; m_op = c; m_bent = 0; m_st = 1;
                end
            end
        end
        if (lat > 0 && !err) push_print();
    endtask

    // Every printed digit must match the next entry the model queued
    always @(negedge clock) begin : cmp
        int e;
        if (!reset && bus.data_valid) begin
            if (exp_q.size() == 0) check("unexpected data_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("print pos", bus.pos, e / 16);
                check("print data", bus.data, e % 16);
                last_burst[e / 16] = bus.data;
            end
        end
    end

    task automatic send(input int c);
        int lat, n, busy;
        bit err, ev;
        @(negedge clock);
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("cmd_ready before command", bus.cmd_ready, 1);
        bus.cmd = 4'(c);
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        model(c, lat, err);
        n = 0;
        busy = 0;
        ev = 0;
        while (!ev && n < (lat == 0 ? 4 : 2 * W)) begin
            @(negedge clock);
            n++;
            busy += int'(bus.status == 2'b01);
            ev = bus.data_valid || (err && bus.status == 2'b00);
        end
        check($sformatf("latency cmd %0d", c), ev ? n : 0, lat);
        check($sformatf("busy cycles cmd %0d", c), busy, lat > 1 ? lat - 1 : 0);
        n = 0;
        while (bus.data_valid && n < 2 * NDIGITS) begin
            @(negedge clock);
            n++;
        end
        check("status after command", bus.status, m_st == 4 ? 0 : 2);
        check("value after command", bus.value, m_val);
        check("state after command", bus.state, m_st);
    endtask

    // Keys: 0-9 digits, + - * / operators, = equals, C backspace/clear
    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte ch;
            ch = s[i];
            send(ch == "+" ? 10 : ch == "-" ? 11 : ch == "*" ? 12 : ch == "/" ? 13 :
                 ch == "=" ? 14 : ch == "C" ? 15 : int'(ch) - 48);
        end
    endtask

    task automatic pin(input string name, input longint lit);
        check({name, " dut value"}, bus.value, lit);
        check({name, " model value"}, m_val, lit);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd = '0;
        bus.cmd_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset status", bus.status, 2);
        check("reset cmd_ready", bus.cmd_ready, 1);
        check("reset data_valid", bus.data_valid, 0);
        check("reset pos", bus.pos, 0);
        check("reset data", bus.data, 0);
        check("reset state", bus.state, 0);
        check("reset value", bus.value, 0);
        reset = 1'b0;
        keys("123");
        pin("digits 123", 123);
        foreach (last_burst[i]) check($sformatf("burst 123 digit %0d", i), last_burst[i], burst_123[i]);
        do_reset();
        keys("99999999");
        pin("max entry", 99999999);
        keys("9");
        pin("overflow digit", 99999999);
        keys("C");
        pin("backspace", 9999999);
        do_reset();
        keys("25+17=");
        pin("add", 42);
        keys("5");
        pin("fresh replace", 5);
        do_reset();
        keys("12*34=");
        pin("mul", 408);
        keys("10000*10000=");
        check("mul overflow status", bus.status, 0);
        keys("7C");
        pin("clear", 0);
        check("clear state", bus.state, 0);
        keys("100/7=");
        pin("div", 14);
        keys("5/0=");
        check("div by zero status", bus.status, 0);
        keys("C3-5=");
        check("sub underflow status", bus.status, 0);
        keys("C2+3*");
        pin("chain add", 5);
        check("chain state", bus.state, 1);
        keys("4=");
        pin("chain mul", 20);
        keys("C6*7");
        @(negedge clock);
        bus.cmd = 4'd14;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("mid-mul busy", bus.status, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset state", bus.state, 0);
        check("async reset status", bus.status, 2);
        check("async reset data_valid", bus.data_valid, 0);
        check("async reset value", bus.value, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (W + 5) @(negedge clock);
        check("no print after abort", bus.data_valid, 0);
        check("status after abort", bus.status, 2);
        check("expected prints drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_param.md
Name: calc_param

Overview:
Parametrised successor of the single-operand-pair decimal calculator FSM. It accepts keypad commands under a valid/ready handshake and builds decimal operands with backspace. It executes add, subtract, and multi-cycle multiply and divide (shift-add and restoring), with overflow, underflow and divide-by-zero detection. After every value change it serialises the NDIGITS-digit display value, one BCD digit per cycle, to the 7-segment display controller.

Parameters:
NDIGITS, 8, number of decimal display digits; maximum value is 10^NDIGITS-1.
W, 27, operand/result register width; must satisfy 2^W > 10^NDIGITS-1.
POS_W, 4, width of the pos output; must satisfy 2^POS_W >= NDIGITS.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd  input  4  command code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 '=', 15 backspace/clear
cmd_valid  input  1  cmd is presented this cycle
cmd_ready  output  1  block accepts cmd this cycle; high only in ENTER_A, ENTER_B, ERROR
status  output  2  00 error, 01 busy (computing), 10 ready, 11 printing
data  output  4  BCD digit being printed
pos  output  POS_W  display position of data; 0 = least-significant digit
data_valid  output  1  data/pos are valid this cycle
state  output  3  current FSM state encoding, for debug: ENTER_A=0, ENTER_B=1, CALC=2, PRINT=3, ERROR=4
value  output  W  current display value

Behaviour:
- Reset (asynchronous): state=ENTER_A, value=0, regA=0, op=add, status=10, data=0, pos=0, data_valid=0, cmd_ready=1. Reset asserted mid-CALC or mid-PRINT aborts immediately with no further data_valid pulses.
- A command is accepted only on a cycle where cmd_valid && cmd_ready. Unaccepted commands are ignored; nothing is queued.
- Digit d in ENTER_A or ENTER_B:
  - If the fresh flag is set, value<=d and fresh is cleared.
  - Else if value*10+d <= 10^NDIGITS-1, value<=value*10+d.
  - Else the digit is ignored; no print is started and status stays 10.
- Backspace in ENTER_A or ENTER_B: value<=value/10; fresh is cleared.
- Operator (10-13):
  - In ENTER_A: regA<=value, op<=cmd, value<=0, b_entered<=0, go to ENTER_B.
  - In ENTER_B with b_entered=0: op<=cmd only; no print.
  - In ENTER_B with b_entered=1: treated as '=' followed by the new op (chaining). regA gets the result and the block returns to ENTER_B after print.
- b_entered is set by any accepted digit in ENTER_B.
- '=' in ENTER_B: regB<=value, go to CALC. '=' in ENTER_A is ignored.
- CALC, status=01, cmd_ready=0:
  - add: 1 cycle. If the sum > 10^NDIGITS-1, go to ERROR.
  - sub: 1 cycle. If regA < regB, go to ERROR (no negatives).
  - mul: shift-add over exactly W cycles. Afterwards, if the product > 10^NDIGITS-1, go to ERROR. Internal accumulator is 2W bits.
  - div: if regB==0, go to ERROR in 1 cycle. Otherwise restoring division over exactly W cycles, quotient truncated.
  - On success: value<=result, fresh<=1, go to PRINT.
- PRINT is entered after every accepted value change (digit, backspace, operator from ENTER_A, successful CALC).
  - status=11, cmd_ready=0.
  - For exactly NDIGITS consecutive cycles: data_valid=1, pos=0..NDIGITS-1, data=(shadow%10), shadow<=shadow/10. shadow is loaded with value on entry.
  - Leading zeros are printed as 0.
  - The cycle after pos=NDIGITS-1: data_valid=0, pos=0, status=10, return to the pending state (ENTER_A, or ENTER_B after operator/chaining).
- ERROR: status=00, cmd_ready=1, value held at 0, no print. Only cmd=15 is accepted; it clears (value=0, regA=0, fresh=0), goes to ENTER_A and prints zeros. All other commands are ignored.
- Latency from accept to first data_valid:
  - digit/backspace/operator: 1 cycle
  - add/sub: 2 cycles after '='
  - mul/div: W+1 cycles after '='

Test Plan:
- Reset, then digits 1,2,3 -> three print bursts. Final burst: data=3,2,1,0,0,0,0,0 at pos 0-7; value=123; status returns to 10.
- 99999999, then '9' -> digit ignored, no data_valid, value stays 99999999. Backspace -> value=9999999 and a print burst.
- 25 + 17 = -> value=42 printed 2 cycles after '='. Then '5' -> value=5 (fresh replace).
- 12 x 34 = -> status=01 for exactly 27 cycles, then 408 printed. 10000 x 10000 = -> ERROR, status=00. cmd 15 -> ENTER_A, zeros printed.
- 100 / 7 = -> 14. 5 / 0 = -> ERROR after 1 cycle. 3 - 5 = -> ERROR.
- 2 + 3 x 4 = -> chaining gives 5 then 20. Reset asserted during the mul CALC -> immediate ENTER_A, status=10, data_valid=0.
